// File: rtl/bcd_convert_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_convert_seq
// Brief    : Sequential double-dabble binary-to-BCD converter. One shift per
//            clock, WIDTH shifts per conversion; the displayed digits are held
//            stable until a conversion completes.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_convert_seq #(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,      // asynchronous, active-low
    input  logic                  start,
    input  logic                  auto,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int c_BW = 4 * DIGITS;
    localparam int c_CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_q,    state_d;
    logic [c_CW-1:0]   count_q,    count_d;
    logic [c_BW-1:0]   digits_q,   digits_d;
    logic [WIDTH-1:0]  operand_q,  operand_d;
    logic              ovf_q,      ovf_d;
    logic [c_BW-1:0]   bcd_q,      bcd_d;
    logic              overflow_q, overflow_d;
    logic              done_q,     done_d;

    logic [c_BW-1:0]   w_adj;
    logic [c_BW-1:0]   w_digits_next;
    logic [WIDTH-1:0]  w_operand_next;
    logic              w_carry_out;

    // Per-digit "add 3 if >= 5" correction; digits are independent, no carry.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign w_adj[4*i +: 4] = (digits_q[4*i +: 4] >= 4'd5) ?
                                 (digits_q[4*i +: 4] + 4'd3) :
                                  digits_q[4*i +: 4];
    end

    // One shift step of the {digits, operand} pair; the operand MSB feeds the
    // ones digit and the top digit's MSB falls out as the overflow indicator.
    assign w_carry_out    = w_adj[c_BW-1];
    assign w_digits_next  = (w_adj << 1) | c_BW'(operand_q[WIDTH-1]);
    assign w_operand_next = operand_q << 1;

    // Next-state, datapath and output-register updates for the converter FSM.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        digits_d   = digits_q;
        operand_d  = operand_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The done cycle is IDLE, so a request here is accepted and
                // auto mode gives one conversion every WIDTH+1 cycles.
                if (start || auto) begin
                    operand_d = bin_in;
                    digits_d  = '0;
                    ovf_d     = 1'b0;
                    count_d   = c_CW'(WIDTH);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                digits_d  = w_digits_next;
                operand_d = w_operand_next;
                ovf_d     = ovf_q | w_carry_out;
                count_d   = count_q - c_CW'(1);
                if (count_q == c_CW'(1)) begin
                    // Publish only the finished result; partial shift states
                    // never reach the display.
                    bcd_d      = w_digits_next;
                    overflow_d = ovf_q | w_carry_out;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            digits_q   <= '0;
            operand_q  <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            digits_q   <= digits_d;
            operand_q  <= operand_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == ST_SHIFT);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_convert_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_convert_seq
// Brief    : Directed self-checking bench for bcd_convert_seq (WIDTH=13 and
//            WIDTH=14 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_convert_seq;

    logic        clk;
    logic        reset;
    logic        start, auto;
    logic [12:0] bin_in;
    logic        busy, done, overflow;
    logic [15:0] bcd_out;

    logic        start14;
    logic [13:0] bin14;
    logic        busy14, done14, overflow14;
    logic [15:0] bcd14;

    int n_assert = 0;
    int n_fail   = 0;

    bcd_convert_seq #(.WIDTH(13), .DIGITS(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .auto(auto), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
    );

    bcd_convert_seq #(.WIDTH(14), .DIGITS(4)) u_dut14 (
        .clk(clk), .reset(reset), .start(start14), .auto(1'b0), .bin_in(bin14),
        .busy(busy14), .done(done14), .bcd_out(bcd14), .overflow(overflow14)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports through an immediate assertion.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decimal conversion for the auto-mode checks.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // One start-triggered conversion on the selected instance; checks latency,
    // busy length, result, overflow and the single-cycle done pulse.
    task automatic convert(input int sel, input int val, input logic [15:0] exp,
                           input logic expov, input string tag);
        int n, nb, w;
        w = (sel == 0) ? 13 : 14;
        if (sel == 0) begin bin_in = 13'(val); start = 1'b1; end
        else          begin bin14  = 14'(val); start14 = 1'b1; end
        @(negedge clk);
        start = 1'b0; start14 = 1'b0;
        n = 1; nb = 0;
        while (!((sel == 0) ? done : done14) && n < 40) begin
            if ((sel == 0) ? busy : busy14) nb++;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, w + 1);
        check({tag, "_busy_cycles"}, nb, w);
        check({tag, "_bcd"}, (sel == 0) ? bcd_out : bcd14, exp);
        check({tag, "_ovf"}, (sel == 0) ? overflow : overflow14, expov);
        check({tag, "_busy_low"}, (sel == 0) ? busy : busy14, 1'b0);
        @(negedge clk);
        check({tag, "_done_single"}, (sel == 0) ? done : done14, 1'b0);
    endtask

    int          hist [0:99];
    int          ndone, last_m;
    logic [15:0] held;
    logic        seen;

    initial begin
        reset = 1'b0; start = 1'b0; auto = 1'b0; bin_in = '0;
        start14 = 1'b0; bin14 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bcd", bcd_out, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // Basic and extreme values
        convert(0, 27,   16'h0027, 1'b0, "c27");
        convert(0, 8191, 16'h8191, 1'b0, "c8191");
        convert(0, 0,    16'h0000, 1'b0, "c0");
        convert(0, 1000, 16'h1000, 1'b0, "c1000");

        // Input change and start while busy are ignored
        bin_in = 13'd4660; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        bin_in = 13'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; held = '0;
        for (int t = 0; t < 30; t++) begin
            if (done) begin ndone++; held = bcd_out; end
            @(negedge clk);
        end
        check("ign_done_count", ndone, 1);
        check("ign_bcd", held, 16'h4660);
        check("ign_no_restart", busy, 1'b0);

        // Auto mode: bin_in changes every 20 cycles
        auto = 1'b1; bin_in = 13'd6;
        last_m = -1; seen = 1'b0; held = '0;
        for (int t = 0; t < 84; t++) begin
            hist[t] = int'(bin_in);
            @(negedge clk);
            if (done) begin
                if (last_m >= 0) check("auto_period", t + 1 - last_m, 14);
                else             check("auto_first", t + 1, 14);
                check("auto_bcd", bcd_out, to_bcd(hist[t + 1 - 14]));
                last_m = t + 1;
                held = bcd_out;
                seen = 1'b1;
            end else if (seen) begin
                if (bcd_out !== held) check("auto_hold", bcd_out, held);
            end
            if (t + 1 == 20) bin_in = 13'd3;
            if (t + 1 == 40) bin_in = 13'd10;
            if (t + 1 == 60) bin_in = 13'd5;
        end
        check("auto_last", bcd_out, 16'h0005);
        auto = 1'b0;
        repeat (3) @(negedge clk);
        check("auto_stopped", busy, 1'b0);

        // Reset in the middle of a conversion
        convert(0, 27, 16'h0027, 1'b0, "pre27");
        bin_in = 13'd8191; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_bcd", bcd_out, 16'h0000);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        check("midrst_bcd_hold", bcd_out, 16'h0000);

        // WIDTH=14 instance, including the overflow case
        convert(1, 9232,  16'h9232, 1'b0, "w14_9232");
        convert(1, 16383, 16'h6383, 1'b1, "w14_16383");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_convert_seq.md
Name: bcd_convert_seq

Overview:
- Sequential double-dabble binary-to-BCD converter. It sits between the Collatz value selector (start number or cycling register value) and the per-digit BCDToLED decoders, and replaces the combinational decimal digit decoder.
- It converts one WIDTH-bit unsigned value in WIDTH shift cycles.
- It holds the last converted digits stable for display while the next conversion runs.
- In auto mode it reconverts back-to-back so the display tracks the 1 Hz register value.

Parameters:
- WIDTH, 13, width of the binary input (the Collatz value width).
- DIGITS, 4, number of BCD digits produced; must be at least 1. Default matches the 4-anode display.

Ports:
- clk  input  1  system clock (5 MHz domain); every register updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request one conversion of bin_in; sampled only in IDLE.
- auto  input  1  when 1, a new conversion starts automatically in every IDLE cycle.
- bin_in  input  WIDTH  unsigned value to convert; sampled on the acceptance edge only.
- busy  output  1  1 while a conversion is in progress.
- done  output  1  single-cycle pulse when new digits become valid.
- bcd_out  output  4*DIGITS  BCD digits; [3:0] = ones, [7:4] = tens, and so on. Default order is thousands, hundreds, tens, ones.
- overflow  output  1  1 if the last converted value exceeded 10^DIGITS-1.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE; shift counter, scratch digits, latched operand, bcd_out, overflow, busy and done all clear to 0.
  - Reset asserted mid-conversion aborts it; bcd_out reads 0 afterwards, not partial data.
- States: IDLE, SHIFT.
- IDLE:
  - busy = 0.
  - If start = 1 or auto = 1 at a rising edge (the acceptance edge, edge 0): latch bin_in into the operand shift register, clear the scratch digits and the internal overflow flag, set the counter to WIDTH, and go to SHIFT with busy = 1.
- SHIFT, one step per edge:
  - Every scratch digit >= 5 has 3 added (a 4-bit add, no inter-digit carry).
  - Then the {scratch digits, operand} pair is shifted left by 1: the operand MSB enters the ones LSB.
  - A 1 shifted out of the top digit's MSB sets the internal overflow flag (sticky for this conversion).
  - The counter decrements.
- Final step (edge WIDTH after acceptance):
  - The post-step scratch digits load bcd_out and the internal flag loads overflow.
  - done = 1 for exactly the following cycle; busy falls to 0 on the same edge; state returns to IDLE.
- Latency: done is high in the cycle after edge WIDTH. Default WIDTH=13 gives 13 cycles from acceptance to valid bcd_out, so back-to-back conversions occur every 14 cycles.
- start while busy = 1 is ignored; there is no queueing.
- start asserted during the done cycle is accepted, because that cycle is IDLE.
- bin_in changes during SHIFT do not affect the conversion in flight.
- bcd_out and overflow change only on a final-step edge or on reset; they hold between conversions. The display never shows intermediate shift states.
- Overflow case: bcd_out holds the value mod 10^DIGITS, i.e. the low digits are still correct. This case is unreachable at the defaults, since 8191 < 9999.
- Every bcd_out nibble is always in the range 0-9.
- Arithmetic: all operations are unsigned. Digit adjust and shift are pure bit operations; no multiply or divide is used.

Test Plan:
- Reset behaviour: hold reset = 0, then release. Pulse start with bin_in = 27. Required: busy = 1 for 13 cycles, then a done pulse; bcd_out = 0x0027; overflow = 0.
- Extremes: bin_in = 8191 gives bcd_out = 0x8191. Then bin_in = 0 gives bcd_out = 0x0000. Then bin_in = 1000 gives 0x1000, with overflow = 0 throughout.
- Input stability and ignored start: accept 4660; one cycle later change bin_in to 9 and pulse start during busy. Required: bcd_out = 0x4660; exactly one done pulse; no second conversion starts.
- Auto mode: set auto = 1 with bin_in stepping 6, 3, 10, 5 every 20 cycles. Required: a done pulse every 14 cycles; bcd_out follows 0x0006, 0x0003, 0x0010, 0x0005; bcd_out is constant between done pulses.
- Reset mid-conversion: assert reset = 0 at cycle 5 of a conversion of 8191 that follows an earlier result of 0x0027. Required: bcd_out = 0, busy = 0, done = 0 immediately (asynchronously); no done pulse after release until a new start.
- WIDTH=14 instance: bin_in = 9232 gives 0x9232 with overflow = 0. bin_in = 16383 gives bcd_out = 0x6383 with overflow = 1.
